// File: rtl/fp_add_pipe.sv
// Pipelined IEEE-754-style FP adder/subtractor with round-to-nearest-even.
// Three register stages (align, add, normalise/round/pack) share one global stall.
module fp_add_pipe #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 flag_nv,
  output logic                 flag_of,
  output logic                 flag_nx
);
  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned SW   = MAN_W + 1;
  localparam int unsigned AW   = MAN_W + 4;
  localparam int unsigned SUMW = MAN_W + 5;
  localparam int unsigned XW   = EXP_W + 2;
  localparam logic [XW-1:0] ExpMax = XW'((1 << EXP_W) - 1);

  logic stall, advance;
  assign stall    = out_valid && !out_ready;
  assign advance  = !stall;
  assign in_ready = advance;

  // ---------------- Stage 1: unpack, order, align, classify ----------------
  logic             signA, signB, effSub, aBig, bigSign;
  logic [EXP_W-1:0] expA, expB, effExpA, effExpB, bigExp, smallExp, expDiff;
  logic [MAN_W-1:0] fracA, fracB;
  logic [SW-1:0]    sigA, sigB, bigSig, smallSig;
  logic [AW-1:0]    smallExt, shifted, lostMask, aligned;
  logic             nanA, nanB, infA, infB, spNaN, spNv, spInf, spInfSign;

  always_comb begin
    signA    = a[W-1];
    signB    = b[W-1] ^ sub;
    expA     = a[W-2:MAN_W];
    expB     = b[W-2:MAN_W];
    fracA    = a[MAN_W-1:0];
    fracB    = b[MAN_W-1:0];
    effSub   = signA ^ signB;
    effExpA  = (expA == '0) ? EXP_W'(1) : expA;
    effExpB  = (expB == '0) ? EXP_W'(1) : expB;
    sigA     = {expA != '0, fracA};
    sigB     = {expB != '0, fracB};
    aBig     = a[W-2:0] >= b[W-2:0];
    bigSign  = aBig ? signA : signB;
    bigExp   = aBig ? effExpA : effExpB;
    smallExp = aBig ? effExpB : effExpA;
    bigSig   = aBig ? sigA : sigB;
    smallSig = aBig ? sigB : sigA;
    expDiff  = bigExp - smallExp;

    // Small significand gains guard/round/sticky slots; shifted-out bits fold into sticky.
    smallExt = {smallSig, 3'b000};
    shifted  = '0;
    lostMask = '0;
    if (32'(expDiff) >= AW) begin
      aligned = {{(AW-1){1'b0}}, |smallSig};
    end else begin
      shifted  = smallExt >> expDiff;
      lostMask = ~({AW{1'b1}} << expDiff);
      aligned  = shifted | {{(AW-1){1'b0}}, |(smallExt & lostMask)};
    end

    nanA      = (expA == '1) && (fracA != '0);
    nanB      = (expB == '1) && (fracB != '0);
    infA      = (expA == '1) && (fracA == '0);
    infB      = (expB == '1) && (fracB == '0);
    spNaN     = nanA || nanB || (infA && infB && effSub);
    spNv      = (nanA && !fracA[MAN_W-1]) || (nanB && !fracB[MAN_W-1]) ||
                (infA && infB && effSub);
    spInf     = infA || infB;
    spInfSign = infA ? signA : signB;
  end

  logic             s1Valid, s1EffSub, s1Sign, s1NaN, s1Nv, s1Inf, s1InfSign;
  logic [EXP_W-1:0] s1Exp;
  logic [SW-1:0]    s1BigSig;
  logic [AW-1:0]    s1Small;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid   <= 1'b0;
      s1EffSub  <= 1'b0;
      s1Sign    <= 1'b0;
      s1NaN     <= 1'b0;
      s1Nv      <= 1'b0;
      s1Inf     <= 1'b0;
      s1InfSign <= 1'b0;
      s1Exp     <= '0;
      s1BigSig  <= '0;
      s1Small   <= '0;
    end else if (advance) begin
      s1Valid   <= in_valid;
      s1EffSub  <= effSub;
      s1Sign    <= bigSign;
      s1NaN     <= spNaN;
      s1Nv      <= spNv;
      s1Inf     <= spInf;
      s1InfSign <= spInfSign;
      s1Exp     <= bigExp;
      s1BigSig  <= bigSig;
      s1Small   <= aligned;
    end
  end

  // ---------------- Stage 2: magnitude add/subtract ----------------
  logic [SUMW-1:0] bigExt, sum;

  always_comb begin
    bigExt = {1'b0, s1BigSig, 3'b000};
    sum    = s1EffSub ? bigExt - {1'b0, s1Small} : bigExt + {1'b0, s1Small};
  end

  logic             s2Valid, s2EffSub, s2Sign, s2NaN, s2Nv, s2Inf, s2InfSign;
  logic [EXP_W-1:0] s2Exp;
  logic [SUMW-1:0]  s2Sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid   <= 1'b0;
      s2EffSub  <= 1'b0;
      s2Sign    <= 1'b0;
      s2NaN     <= 1'b0;
      s2Nv      <= 1'b0;
      s2Inf     <= 1'b0;
      s2InfSign <= 1'b0;
      s2Exp     <= '0;
      s2Sum     <= '0;
    end else if (advance) begin
      s2Valid   <= s1Valid;
      s2EffSub  <= s1EffSub;
      s2Sign    <= s1Sign;
      s2NaN     <= s1NaN;
      s2Nv      <= s1Nv;
      s2Inf     <= s1Inf;
      s2InfSign <= s1InfSign;
      s2Exp     <= s1Exp;
      s2Sum     <= sum;
    end
  end

  // ---------------- Stage 3: normalise, round, pack ----------------
  logic [AW-1:0]    lowSum, norm;
  logic [XW-1:0]    normExp, finExp;
  int unsigned      lzc, shAmt;
  logic [SW-1:0]    mant;
  logic [MAN_W+1:0] mantR;
  logic [MAN_W-1:0] fracOut;
  logic             guardBit, roundBit, stickyBit, roundUp, inexact, ovf, resSign;
  logic [W-1:0]     resD;
  logic             nvD, ofD, nxD;

  always_comb begin
    lowSum = s2Sum[AW-1:0];
    lzc    = AW;
    for (int i = 0; i < AW; i++) begin
      if (lowSum[i]) lzc = AW - 1 - i;
    end
    shAmt = 0;
    if (s2Sum[SUMW-1]) begin
      norm    = {s2Sum[SUMW-1:2], s2Sum[1] | s2Sum[0]};
      normExp = XW'(s2Exp) + XW'(1);
    end else begin
      // Never normalise below exponent 1; what is left packs as a subnormal.
      shAmt   = (lzc < 32'(s2Exp) - 32'd1) ? lzc : 32'(s2Exp) - 32'd1;
      norm    = lowSum << shAmt;
      normExp = XW'(s2Exp) - XW'(shAmt);
    end

    mant      = norm[AW-1:3];
    guardBit  = norm[2];
    roundBit  = norm[1];
    stickyBit = norm[0];
    roundUp   = guardBit && (roundBit || stickyBit || mant[0]);
    inexact   = guardBit || roundBit || stickyBit;
    mantR     = {1'b0, mant} + {{(MAN_W+1){1'b0}}, roundUp};

    if (mantR[MAN_W+1]) begin
      finExp  = normExp + XW'(1);
      fracOut = mantR[MAN_W:1];
    end else if (mantR[MAN_W]) begin
      finExp  = normExp;
      fracOut = mantR[MAN_W-1:0];
    end else begin
      finExp  = '0;
      fracOut = mantR[MAN_W-1:0];
    end
    ovf = finExp >= ExpMax;

    // Exact zero: +0 for a difference, operand sign for (-0)+(-0).
    resSign = (s2Sum == '0) ? (s2Sign && !s2EffSub) : s2Sign;

    nvD = 1'b0;
    ofD = 1'b0;
    nxD = 1'b0;
    if (s2NaN) begin
      resD = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      nvD  = s2Nv;
    end else if (s2Inf) begin
      resD = {s2InfSign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (ovf) begin
      resD = {resSign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ofD  = 1'b1;
      nxD  = 1'b1;
    end else begin
      resD = {resSign, finExp[EXP_W-1:0], fracOut};
      nxD  = inexact;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flag_nv   <= 1'b0;
      flag_of   <= 1'b0;
      flag_nx   <= 1'b0;
    end else if (advance) begin
      out_valid <= s2Valid;
      result    <= resD;
      flag_nv   <= nvD;
      flag_of   <= ofD;
      flag_nx   <= nxD;
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Bench for fp_add_pipe: directed vectors, handshake/stall behaviour, reset, and a randomized
// stream scored against an exact-integer half-precision reference model.
module tb_fp_add_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, sub, out_valid, out_ready;
  logic [15:0] a, b, result;
  logic        flag_nv, flag_of, flag_nx;

  logic        wInValid, wInReady, wSub, wOutValid, wOutReady;
  logic [31:0] wA, wB, wResult;
  logic        wNv, wOf, wNx;

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  fp_add_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_nv(flag_nv), .flag_of(flag_of), .flag_nx(flag_nx)
  );

  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dutWide (
    .clk(clk), .rst_n(rst_n), .in_valid(wInValid), .in_ready(wInReady), .a(wA), .b(wB),
    .sub(wSub), .out_valid(wOutValid), .out_ready(wOutReady), .result(wResult),
    .flag_nv(wNv), .flag_of(wOf), .flag_nx(wNx)
  );

  // {a, b, sub, result, {nv, of, nx}}
  localparam logic [51:0] DIR [12] = '{
    {16'h3C00, 16'h4000, 1'b0, 16'h4200, 3'b000},
    {16'h4000, 16'h3C00, 1'b1, 16'h3C00, 3'b000},
    {16'h3C00, 16'h1000, 1'b0, 16'h3C00, 3'b001},
    {16'h3C01, 16'h1000, 1'b0, 16'h3C02, 3'b001},
    {16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b011},
    {16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 3'b100},
    {16'h7D00, 16'h3C00, 1'b0, 16'h7E00, 3'b100},
    {16'hFC00, 16'h3C00, 1'b0, 16'hFC00, 3'b000},
    {16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3'b000},
    {16'h8000, 16'h8000, 1'b0, 16'h8000, 3'b000},
    {16'h0001, 16'h0001, 1'b0, 16'h0002, 3'b000},
    {16'h0400, 16'h0001, 1'b1, 16'h03FF, 3'b000}
  };

  // Half-precision reference: every finite half is an integer multiple of 2^-24, so the sum
  // is computed exactly in those units and then rounded to nearest-even by remainder.
  function automatic logic [18:0] refAdd(input logic [15:0] x, input logic [15:0] y,
                                         input logic s);
    logic   sx, sy, nanX, nanY, infX, infY, sign, nx;
    int     ex, ey, e, sh;
    longint vx, vy, sum, mag, q, rem, half;
    sx   = x[15];
    sy   = y[15] ^ s;
    ex   = int'(x[14:10]);
    ey   = int'(y[14:10]);
    nanX = (ex == 31) && (x[9:0] != 0);
    nanY = (ey == 31) && (y[9:0] != 0);
    infX = (ex == 31) && (x[9:0] == 0);
    infY = (ey == 31) && (y[9:0] == 0);
    if (nanX || nanY) return {16'h7E00, (nanX && !x[9]) || (nanY && !y[9]), 2'b00};
    if (infX && infY && sx != sy) return {16'h7E00, 3'b100};
    if (infX) return {sx, 15'h7C00, 3'b000};
    if (infY) return {sy, 15'h7C00, 3'b000};
    vx = (longint'(x[9:0]) + ((ex != 0) ? 1024 : 0)) << ((ex == 0) ? 0 : ex - 1);
    vy = (longint'(y[9:0]) + ((ey != 0) ? 1024 : 0)) << ((ey == 0) ? 0 : ey - 1);
    if (sx) vx = -vx;
    if (sy) vy = -vy;
    sum = vx + vy;
    if (sum == 0) begin
      sign = (x[14:0] == 0 && y[14:0] == 0 && sx == sy) ? sx : 1'b0;
      return {sign, 15'h0000, 3'b000};
    end
    sign = sum < 0;
    mag  = sign ? -sum : sum;
    if (mag < 1024) return {sign, 5'h00, 10'(mag), 3'b000};
    e = 1;
    while ((mag >> (e - 1)) >= 2048) e++;
    sh  = e - 1;
    q   = mag >> sh;
    rem = mag - (q << sh);
    nx  = rem != 0;
    if (sh > 0) begin
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
    end
    if (q == 2048) begin
      q = 1024;
      e++;
    end
    if (e >= 31) return {sign, 15'h7C00, 3'b011};
    return {sign, 5'(e), 10'(q), 2'b00, nx};
  endfunction

  task automatic genOp(output logic [15:0] x, output logic [15:0] y, output logic s);
    x = 16'($urandom);
    y = 16'($urandom);
    s = 1'($urandom);
    case ($urandom_range(0, 3))
      0: ;
      1: y = x ^ 16'($urandom_range(0, 7));
      2: y[14:10] = x[14:10] - 5'($urandom_range(0, 15));
      default: begin
        x[14:10] = 5'($urandom_range(0, 1));
        y = {1'($urandom), 15'($urandom_range(0, 2047))};
      end
    endcase
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
    wInValid = 1'b0; wOutReady = 1'b1; wA = '0; wB = '0; wSub = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    nChecks++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid);
    else nPass++;
    nChecks++;
    if ({result, flag_nv, flag_of, flag_nx} !== 19'h0)
      $display("FAIL reset_outputs got %h/%b%b%b want 0", result, flag_nv, flag_of, flag_nx);
    else nPass++;
    nChecks++;
    if (wOutValid !== 1'b0 || wResult !== 32'h0)
      $display("FAIL reset_wide got %b/%h want 0/0", wOutValid, wResult);
    else nPass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    nChecks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
    else nPass++;
  endtask

  task automatic test_directed();
    logic [51:0] v;
    int          lat;
    for (int i = 0; i < 12; i++) begin
      v = DIR[i];
      @(negedge clk);
      a = v[51:36]; b = v[35:20]; sub = v[19]; in_valid = 1'b1; out_ready = 1'b1;
      lat = 0;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        if (out_valid === 1'b1) begin
          lat = c;
          break;
        end
      end
      nChecks++;
      if (lat != 3) $display("FAIL dir%0d_latency got %0d want 3", i, lat);
      else nPass++;
      nChecks++;
      if (result !== v[18:3]) $display("FAIL dir%0d_result got %h want %h", i, result, v[18:3]);
      else nPass++;
      nChecks++;
      if ({flag_nv, flag_of, flag_nx} !== v[2:0])
        $display("FAIL dir%0d_flags got %b want %b", i, {flag_nv, flag_of, flag_nx}, v[2:0]);
      else nPass++;
    end
  endtask

  // readyMode: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random (with input bubbles)
  task automatic test_stream(input string name, input int nOps, input int readyMode);
    logic [18:0] expQ[$];
    logic [18:0] got, want, prevOut;
    logic [15:0] x, y;
    logic        s, offering, prevStall;
    logic [3:0]  pat;
    int          issued, received, firstOut, lastOut;
    pat = 4'b1001;
    issued = 0; received = 0; firstOut = -1; lastOut = -1;
    offering = 1'b0; prevStall = 1'b0; prevOut = '0;
    x = '0; y = '0; s = 1'b0;
    for (int cyc = 0; cyc < nOps * 8 + 20 && received < nOps; cyc++) begin
      @(negedge clk);
      if (!offering && issued < nOps && (readyMode != 2 || $urandom_range(0, 3) != 0)) begin
        genOp(x, y, s);
        offering = 1'b1;
      end
      a = x; b = y; sub = s; in_valid = offering;
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[cyc % 4];
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      #1;
      got = {result, flag_nv, flag_of, flag_nx};
      nChecks++;
      if (in_ready !== !(out_valid && !out_ready))
        $display("FAIL %s_in_ready cyc%0d got %b want %b", name, cyc, in_ready,
                 !(out_valid && !out_ready));
      else nPass++;
      if (prevStall) begin
        nChecks++;
        if (got !== prevOut) $display("FAIL %s_hold cyc%0d got %h want %h", name, cyc, got, prevOut);
        else nPass++;
      end
      if (out_valid && out_ready) begin
        nChecks++;
        if (expQ.size() == 0) begin
          $display("FAIL %s_extra cyc%0d got %h want no output", name, cyc, got);
        end else begin
          want = expQ.pop_front();
          if (got !== want)
            $display("FAIL %s_result #%0d got %h/%b want %h/%b", name, received, got[18:3],
                     got[2:0], want[18:3], want[2:0]);
          else nPass++;
          received++;
          if (firstOut < 0) firstOut = cyc;
          lastOut = cyc;
        end
      end
      if (in_valid && in_ready) begin
        expQ.push_back(refAdd(x, y, s));
        issued++;
        offering = 1'b0;
      end
      prevStall = out_valid && !out_ready;
      prevOut   = got;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    nChecks++;
    if (received != nOps) $display("FAIL %s_count got %0d want %0d", name, received, nOps);
    else nPass++;
    if (readyMode == 0) begin
      nChecks++;
      if (lastOut - firstOut != nOps - 1)
        $display("FAIL %s_rate got %0d cycles want %0d", name, lastOut - firstOut, nOps - 1);
      else nPass++;
    end
  endtask

  task automatic test_reset_inflight();
    int spurious, seen;
    out_ready = 1'b0;
    @(negedge clk);
    a = 16'h3C00; b = 16'h4000; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h4000; b = 16'h3C00; sub = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    nChecks++;
    if (out_valid !== 1'b1) $display("FAIL rst_pre_valid got %b want 1", out_valid);
    else nPass++;
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (out_valid !== 1'b0 || result !== 16'h0000)
      $display("FAIL rst_async got %b/%h want 0/0000", out_valid, result);
    else nPass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    a = 16'h3C00; b = 16'h3C00; sub = 1'b0; in_valid = 1'b1;
    #1;
    nChecks++;
    if (in_ready !== 1'b1) $display("FAIL rst_first_ready got %b want 1", in_ready);
    else nPass++;
    spurious = 0; seen = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid === 1'b1) begin
        if (c == 3 && result === 16'h4000 && seen == 0) seen = 1;
        else spurious++;
      end
    end
    nChecks++;
    if (spurious != 0) $display("FAIL rst_discard got %0d stale outputs want 0", spurious);
    else nPass++;
    nChecks++;
    if (seen != 1) $display("FAIL rst_first_op got %0d results want 1", seen);
    else nPass++;
  endtask

  task automatic test_wide();
    logic [31:0] wa [2] = '{32'h3F800000, 32'h40000000};
    logic [31:0] wb [2] = '{32'h40000000, 32'h3F800000};
    logic [31:0] wr [2] = '{32'h40400000, 32'h3F800000};
    int lat;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      wA = wa[i]; wB = wb[i]; wSub = (i == 1); wInValid = 1'b1;
      lat = 0;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        wInValid = 1'b0;
        #1;
        if (wOutValid === 1'b1) begin
          lat = c;
          break;
        end
      end
      nChecks++;
      if (lat != 3) $display("FAIL wide%0d_latency got %0d want 3", i, lat);
      else nPass++;
      nChecks++;
      if (wResult !== wr[i] || {wNv, wOf, wNx} !== 3'b000)
        $display("FAIL wide%0d_result got %h/%b want %h/000", i, wResult, {wNv, wOf, wNx}, wr[i]);
      else nPass++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    test_reset();
    test_directed();
    test_stream("backpressure", 8, 1);
    test_stream("throughput", 16, 0);
    test_stream("random", 400, 2);
    test_reset_inflight();
    test_wide();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
